hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised hazard and forwarding controller for the 5-stage pipeline, replacing the single-issue combinational forwarding unit. It tracks destination and source register tags of the EX, MEM and WB stages in its own shadow pipeline. It produces independent per-operand forwarding selects for the instruction in EX and detects load-use hazards. On a load-use hazard it stalls IF/ID and inserts a bubble into EX.

## Interface
Parameters:
- AW, 5: register address width.
- NSRC, 2: source operands per instruction.
- CNT_W, 16: stall counter width (only with HAZARD_STALL_CNT_EN).

Ports:
- clk  in  1  pipeline clock; one clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- adv  in  1  pipeline advance; 0 freezes all shadow stages (e.g. memory busy).
- flush  in  1  branch/jump flush; instruction leaving ID becomes a bubble.
- id_valid  in  1  ID stage holds a real instruction.
- id_src  in  NSRC*AW  ID source tags, operand i at bits [i*AW +: AW].
- id_rd  in  AW  ID destination tag.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- fwd_sel  out  2*NSRC  per operand: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- stall  out  1  hold PC and IF/ID; the bubble goes into EX.
- stall_cnt  out  CNT_W  saturating count of inserted load-use bubbles (macro only).

## Operation
- Shadow stages EX, MEM and WB each hold {valid, rd, regwrite, memread, src[NSRC]}.
- On a clk edge with adv=1:
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields with valid=id_valid, unless stall=1 or flush=1, in which case EX<=bubble (valid=0, regwrite=0, memread=0, tags 0).
- On a clk edge with adv=0, all stages hold.
- A stage is "writing" iff valid && regwrite && rd!=0.
- Forwarding is combinational and evaluated for each operand i independently:
  - 10 if MEM is writing and MEM.rd==EX.src[i];
  - else 01 if WB is writing and WB.rd==EX.src[i];
  - else 00.
  - MEM has priority over WB. Operands never block each other; both operands may forward in the same cycle.
- stall is combinational: id_valid && EX writing && EX.memread && any id_src[i]==EX.rd.
- flush overrides stall: if flush=1, stall=0 and the EX bubble is caused by flush.
- A stall lasts exactly as long as the hazard persists with adv=1; it lasts one cycle in normal flow.
- With adv=0 and a hazard present, stall stays 1 and no bubble is counted until adv=1.

## Timing
- Reset (rst_n=0, asynchronous): all shadow stages are bubbles, fwd_sel=0, stall=0, stall_cnt=0. The block is operational on the first edge after deassertion.
- fwd_sel and stall are combinational from current shadow state and ID inputs, with zero-cycle latency. The shadow state updates on the rising edge.
- Load followed by a dependent instruction:
  - Cycle N: stall=1.
  - Edge N: bubble enters EX and the load enters MEM.
  - Cycle N+1: stall=0.
  - Edge N+1: the dependent instruction enters EX with fwd_sel=01 for the matching operand. The load is then in WB.
- Reset asserted mid-stall clears state immediately; stall drops asynchronously with the state.
- Register 0 never forwards and never stalls.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_cnt is present.
  - It increments on each edge with adv=1 && stall=1 && flush=0.
  - It saturates at 2^CNT_W-1 and never wraps.
- HAZARD_STALL_CNT_EN undefined: the stall_cnt port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 three cycles with random ID inputs -> fwd_sel=0000, stall=0, stall_cnt=0; after release, first instruction sees no forwarding.
- Back-to-back ALU (add r3 then sub using src0=r3, src1=r3) -> dependent in EX gets fwd_sel=1010; one instruction later, a third reader of r3 sees 0101.
- Load-use: lw r5 then add src1=r5 -> stall=1 for exactly 1 cycle; dependent then reaches EX with fwd_sel[3:2]=01; stall_cnt=1.
- adv=0 for 4 cycles during load-use -> stall stays 1, shadows frozen, stall_cnt unchanged until adv returns; then increments by 1.
- flush=1 coincident with a load-use hazard -> stall=0, EX becomes bubble, stall_cnt unchanged; writes to r0 with readers of r0 -> fwd_sel=00, no stall.
- Saturation with CNT_W=2: five load-use bubbles -> stall_cnt=3.

Source files
------------

// File: rtl/hazard_fwd_unit_if.sv
// Hazard/forwarding unit bus: ID-stage instruction fields and pipeline control
// in, per-operand forwarding selects and stall out.
// Optional stall counter signal present when HAZARD_STALL_CNT_EN is defined.
interface hazard_fwd_unit_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned CNT_W = 16
);
  logic                   adv;
  logic                   flush;
  logic                   id_valid;
  logic [NSRC*AW-1:0]     id_src;
  logic [AW-1:0]          id_rd;
  logic                   id_regwrite;
  logic                   id_memread;
  logic [2*NSRC-1:0]      fwd_sel;
  logic                   stall;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0]       stall_cnt;
`endif

  // Pipeline side: drives the ID fields, consumes the hazard decisions
  modport master (
    output adv, flush, id_valid, id_src, id_rd, id_regwrite, id_memread,
`ifdef HAZARD_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  fwd_sel, stall
  );

  // Hazard unit side
  modport slave (
    input  adv, flush, id_valid, id_src, id_rd, id_regwrite, id_memread,
`ifdef HAZARD_STALL_CNT_EN
    output stall_cnt,
`endif
    output fwd_sel, stall
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Keeps a shadow copy of the EX/MEM/WB register tags, drives per-operand
// forwarding selects for EX and stalls IF/ID on load-use hazards.
// Optional: HAZARD_STALL_CNT_EN adds a saturating load-use bubble counter.
module hazard_fwd_unit #(
  parameter int unsigned AW    = 5,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_fwd_unit_if.slave  hif
);

  // EX needs sources and load flag; MEM/WB only feed forwarding decisions
  typedef struct packed {
    logic               valid;
    logic [AW-1:0]      rd;
    logic               regwrite;
    logic               memread;
    logic [NSRC*AW-1:0] src;
  } ex_stage_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regwrite;
  } wr_stage_t;

  ex_stage_t ex_q;
  ex_stage_t ex_d;
  wr_stage_t mem_q;
  wr_stage_t wb_q;
  logic      ex_wr;
  logic      mem_wr;
  logic      wb_wr;
  logic      src_hit;

  assign ex_wr  = ex_q.valid  && ex_q.regwrite  && (ex_q.rd  != '0);
  assign mem_wr = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);
  assign wb_wr  = wb_q.valid  && wb_q.regwrite  && (wb_q.rd  != '0);

  // Next EX contents: ID instruction, or a bubble on stall/flush
  always_comb begin
    ex_d = '0;
    if (!(hif.stall || hif.flush)) begin
      ex_d.valid    = hif.id_valid;
      ex_d.rd       = hif.id_rd;
      ex_d.regwrite = hif.id_regwrite;
      ex_d.memread  = hif.id_memread;
      ex_d.src      = hif.id_src;
    end
  end

  // Shadow pipeline shifts only when the real pipeline advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (hif.adv) begin
      ex_q  <= ex_d;
      mem_q <= wr_stage_t'{ex_q.valid, ex_q.rd, ex_q.regwrite};
      wb_q  <= mem_q;
    end
  end

  // Per-operand forwarding (MEM wins over WB) and load-use detection
  always_comb begin
    hif.fwd_sel = '0;
    src_hit     = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (mem_wr && (mem_q.rd == ex_q.src[i*AW +: AW])) begin
        hif.fwd_sel[2*i +: 2] = 2'b10;
      end else if (wb_wr && (wb_q.rd == ex_q.src[i*AW +: AW])) begin
        hif.fwd_sel[2*i +: 2] = 2'b01;
      end
      if (hif.id_src[i*AW +: AW] == ex_q.rd) begin
        src_hit = 1'b1;
      end
    end
    hif.stall = !hif.flush && hif.id_valid && ex_wr && ex_q.memread && src_hit;
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count inserted load-use bubbles, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (hif.adv && hif.stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hif.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios with literal
// expectations plus randomized traffic against an instruction-level model.
`timescale 1ns/1ps
module tb_hazard_fwd_unit;
  localparam int unsigned AW   = 5;
  localparam int unsigned NSRC = 2;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.AW(AW), .NSRC(NSRC), .CNT_W(CW)) hif();
  hazard_fwd_unit #(.AW(AW), .NSRC(NSRC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  int checks = 0;
  int errors = 0;

  // Model: index 0 = EX, 1 = MEM, 2 = WB; each entry is one instruction
  bit       mv  [3];
  bit [4:0] mrd [3];
  bit       mrw [3];
  bit       mmr [3];
  bit [4:0] msrc[3][2];
  int       mcnt;

  function automatic bit m_writes(int k);
    return mv[k] && mrw[k] && (mrd[k] != 5'd0);
  endfunction

  function automatic logic [3:0] m_fwd();
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      if (m_writes(1) && mrd[1] == msrc[0][i]) r[2*i+1] = 1'b1;
      else if (m_writes(2) && mrd[2] == msrc[0][i]) r[2*i] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit m_stall();
    logic [9:0] s;
    s = hif.id_src;
    if (hif.flush || !hif.id_valid || !m_writes(0) || !mmr[0]) return 1'b0;
    return (s[4:0] == mrd[0]) || (s[9:5] == mrd[0]);
  endfunction

  // Model advance: instructions move one stage per advancing edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mv[k] = 0; mrd[k] = 0; mrw[k] = 0; mmr[k] = 0;
        msrc[k][0] = 0; msrc[k][1] = 0;
      end
      mcnt = 0;
    end else if (hif.adv) begin
      bit st;
      logic [9:0] s;
      st = m_stall();
      s  = hif.id_src;
      if (st && mcnt < CMAX) mcnt = mcnt + 1;
      for (int k = 2; k >= 1; k--) begin
        mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; mrw[k] = mrw[k-1]; mmr[k] = mmr[k-1];
        msrc[k][0] = msrc[k-1][0]; msrc[k][1] = msrc[k-1][1];
      end
      if (st || hif.flush) begin
        mv[0] = 0; mrd[0] = 0; mrw[0] = 0; mmr[0] = 0; msrc[0][0] = 0; msrc[0][1] = 0;
      end else begin
        mv[0] = hif.id_valid; mrd[0] = hif.id_rd; mrw[0] = hif.id_regwrite;
        mmr[0] = hif.id_memread; msrc[0][0] = s[4:0]; msrc[0][1] = s[9:5];
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against model every cycle, mid-cycle
  always @(negedge clk) begin
    chk("model_fwd_sel", int'(hif.fwd_sel), int'(m_fwd()));
    chk("model_stall", int'(hif.stall), int'(m_stall()));
`ifdef HAZARD_STALL_CNT_EN
    chk("model_stall_cnt", int'(hif.stall_cnt), mcnt);
`endif
  end

  task automatic chk_cnt(string name, int exp);
`ifdef HAZARD_STALL_CNT_EN
    chk(name, int'(hif.stall_cnt), exp);
`endif
  endtask

  // One cycle: drive ID fields just after the edge, settle before checks
  task automatic put(bit v, int s0, int s1, int rd, bit rw, bit mr, bit a, bit f);
    @(posedge clk);
    #1;
    hif.id_valid    = v;
    hif.id_src      = {5'(s1), 5'(s0)};
    hif.id_rd       = 5'(rd);
    hif.id_regwrite = rw;
    hif.id_memread  = mr;
    hif.adv         = a;
    hif.flush       = f;
    #2;
  endtask

  initial begin
    hif.adv = 1'b1; hif.flush = 1'b0; hif.id_valid = 1'b0; hif.id_src = '0;
    hif.id_rd = '0; hif.id_regwrite = 1'b0; hif.id_memread = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with random ID activity
    repeat (3) begin
      put(1'b1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      chk("rst_fwd_sel", int'(hif.fwd_sel), 0);
      chk("rst_stall", int'(hif.stall), 0);
      chk_cnt("rst_stall_cnt", 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hif.id_valid = 1'b0;

    // Back-to-back ALU dependencies
    put(1, 1, 2, 3, 1, 0, 1, 0);
    put(1, 3, 3, 4, 1, 0, 1, 0);
    chk("first_fwd", int'(hif.fwd_sel), 0);
    put(1, 3, 3, 8, 1, 0, 1, 0);
    chk("alu_fwd_mem", int'(hif.fwd_sel), 4'b1010);
    put(0, 0, 0, 0, 0, 0, 1, 0);
    chk("alu_fwd_wb", int'(hif.fwd_sel), 4'b0101);

    // Load-use: one bubble, then forward from WB
    put(1, 9, 0, 5, 1, 1, 1, 0);
    put(1, 1, 5, 7, 1, 0, 1, 0);
    chk("lu_stall", int'(hif.stall), 1);
    put(1, 1, 5, 7, 1, 0, 1, 0);
    chk("lu_stall_end", int'(hif.stall), 0);
    put(0, 0, 0, 0, 0, 0, 1, 0);
    chk("lu_fwd", int'(hif.fwd_sel), 4'b0100);
    chk_cnt("lu_cnt", 1);

    // Load-use held by adv=0
    put(1, 9, 0, 5, 1, 1, 1, 0);
    repeat (4) begin
      put(1, 5, 2, 6, 1, 0, 0, 0);
      chk("frz_stall", int'(hif.stall), 1);
      chk_cnt("frz_cnt", 1);
    end
    put(1, 5, 2, 6, 1, 0, 1, 0);
    chk("frz_release_stall", int'(hif.stall), 1);
    chk_cnt("frz_release_cnt", 1);
    put(1, 5, 2, 6, 1, 0, 1, 0);
    chk("frz_after_stall", int'(hif.stall), 0);
    chk_cnt("frz_after_cnt", 2);

    // Flush overrides a load-use hazard
    put(0, 0, 0, 0, 0, 0, 1, 0);
    put(1, 9, 0, 5, 1, 1, 1, 0);
    put(1, 5, 5, 6, 1, 0, 1, 1);
    chk("flush_stall", int'(hif.stall), 0);
    put(1, 5, 5, 6, 1, 0, 1, 0);
    chk("flush_bubble_fwd", int'(hif.fwd_sel), 0);
    chk("flush_bubble_stall", int'(hif.stall), 0);
    chk_cnt("flush_cnt", 2);

    // Register 0 never forwards or stalls
    put(1, 1, 2, 0, 1, 1, 1, 0);
    put(1, 0, 0, 6, 1, 0, 1, 0);
    chk("r0_stall", int'(hif.stall), 0);
    put(1, 0, 0, 0, 1, 0, 1, 0);
    chk("r0_fwd_load", int'(hif.fwd_sel), 0);
    put(1, 0, 0, 7, 1, 0, 1, 0);
    put(0, 0, 0, 0, 0, 0, 1, 0);
    chk("r0_fwd_alu", int'(hif.fwd_sel), 0);

    // Counter saturation
    repeat (5) begin
      put(1, 9, 0, 5, 1, 1, 1, 0);
      put(1, 1, 5, 7, 1, 0, 1, 0);
      chk("sat_stall", int'(hif.stall), 1);
      put(1, 1, 5, 7, 1, 0, 1, 0);
    end
    put(0, 0, 0, 0, 0, 0, 1, 0);
    chk_cnt("sat_cnt", CMAX);

    // Asynchronous reset in the middle of a stall
    put(1, 9, 0, 5, 1, 1, 1, 0);
    put(1, 5, 0, 7, 1, 0, 1, 0);
    chk("mid_rst_pre", int'(hif.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", int'(hif.stall), 0);
    chk("mid_rst_fwd", int'(hif.fwd_sel), 0);
    chk_cnt("mid_rst_cnt", 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      put(1'($urandom_range(0, 99) < 85), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), 1'($urandom_range(0, 99) < 75),
          1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 80),
          1'($urandom_range(0, 99) < 10));
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
